v_wb_2: RTL
===========

V_WB_2 -- requirements
Module: v_wb_2

Interface
REQ-001 SHALL take parameters, one per line:
- VREG_DW, 256, vector register width in bits.
- VREG_AW, 5, vector register address width.
- DEPTH, 4, result buffer entries (power of two, at least 2).
REQ-002 SHALL have these ports; one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- res_valid_i  in  1  result from v_alu_2 lane present.
- res_ready_o  out  1  buffer can accept a result.
- res_wen_i  in  1  result must be written to the VRF.
- res_vd_i  in  VREG_AW  destination vector register.
- res_data_i  in  VREG_DW  valu_result_o of v_alu_2.
- vrf_wen_o  out  1  write request to the VRF write port.
- vrf_waddr_o  out  VREG_AW  write address (head entry).
- vrf_wdata_o  out  VREG_DW  write data (head entry).
- vrf_wgnt_i  in  1  VRF write port granted this cycle.
- byp_raddr_i  in  VREG_AW  register being read by issue.
- byp_hit_o  out  1  a buffered entry targets byp_raddr_i.
- byp_data_o  out  VREG_DW  data of the youngest matching entry.
- pending_o  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-003 SHALL implement a circular FIFO with wr_ptr, rd_ptr and count registers; pointers wrap from DEPTH-1 to 0.
REQ-004 SHALL drive res_ready_o = (count != DEPTH), from registered state only, with no combinational path from vrf_wgnt_i.
REQ-005 SHALL accept when res_valid_i && res_ready_o.
- Accepted with res_wen_i=1: SHALL store {vd, data} at wr_ptr and advance wr_ptr.
- Accepted with res_wen_i=0: SHALL be consumed and discarded, with no state change.
REQ-006 SHALL drive vrf_wen_o = (count != 0), with vrf_waddr_o/vrf_wdata_o taken from the rd_ptr entry; pop SHALL occur when vrf_wen_o && vrf_wgnt_i.
REQ-007 On simultaneous push and pop, SHALL keep count unchanged and advance both pointers.
REQ-008 SHALL NOT push when full, even if a pop occurs in the same cycle.
REQ-009 SHALL hold vrf_waddr_o/vrf_wdata_o stable while vrf_wen_o=1 and vrf_wgnt_i=0.
REQ-010 SHALL deliver write order to the VRF identical to acceptance order.
- Latency: an entry pushed into an empty buffer is presented on vrf_wen_o in the next cycle.
REQ-011 Bypass SHALL be combinational over occupied entries only.
- byp_hit_o=1 iff any occupied entry has vd == byp_raddr_i.
- byp_data_o SHALL be the data of the youngest (most recently pushed) match.
- byp_data_o SHALL be 0 when byp_hit_o=0.
- The incoming res_* beat SHALL NOT be searched.
REQ-012 An entry popped in the current cycle SHALL still participate in the bypass search during that cycle.
REQ-013 SHALL drive pending_o equal to count.
REQ-014 Register address 0 SHALL be treated as an ordinary register, with no special casing.

Reset
REQ-015 On rst=1 at a clock edge, SHALL clear count, wr_ptr and rd_ptr to 0.
- Result: vrf_wen_o=0, byp_hit_o=0, byp_data_o=0, pending_o=0, res_ready_o=1 in the following cycle.
REQ-016 Reset SHALL take priority over a push or pop in the same cycle; buffered entries are lost.
REQ-017 Storage arrays SHALL NOT be reset.

Structure
REQ-018 A shared package v_pkg SHALL hold VREG_DW, VREG_AW, VWB_DEPTH and the VALU opcode constants (NOP=0, VADD=1, VMUL=2).
REQ-019 SHALL contain one sub-module, v_wb_match: a DEPTH-way youngest-first address-match priority selector returning hit and index.

Verification
REQ-020 Push vd=3 data=0xA5.., grant held 1 -> vrf_wen_o=1 the next cycle with waddr=3, data=0xA5..; pending_o returns to 0 one cycle later.
REQ-021 Grant held 0, push 4 results -> res_ready_o=0, pending_o=4; a 5th beat is not accepted; after one grant cycle, res_ready_o=1.
REQ-022 Push vd=7 data=1, then vd=7 data=2, grant 0, byp_raddr_i=7 -> byp_hit_o=1, byp_data_o=2; byp_raddr_i=8 -> byp_hit_o=0, byp_data_o=0.
REQ-023 Push with res_wen_i=0 -> res_ready_o stays 1, pending_o stays 0, vrf_wen_o stays 0.
REQ-024 Full buffer with a push and grant in the same cycle -> pop only, pending_o=3; pointers wrap correctly over 10 random push/pop cycles against a reference FIFO model.
REQ-025 Assert rst with 3 entries pending -> next cycle pending_o=0, vrf_wen_o=0, byp_hit_o=0.

Source files
------------

// File: rtl/v_pkg.sv
// rtl/v_pkg.sv - shared vector-unit constants and VALU opcodes
package v_pkg;

    localparam int VREG_DW   = 256;
    localparam int VREG_AW   = 5;
    localparam int VWB_DEPTH = 4;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        VADD = 2'd1,
        VMUL = 2'd2
    } valu_op_e;

endpackage

// File: rtl/v_wb_2_if.sv
// rtl/v_wb_2_if.sv - result, VRF write and bypass signals of the write-back buffer
interface v_wb_2_if #(
    parameter int VREG_DW = v_pkg::VREG_DW,
    parameter int VREG_AW = v_pkg::VREG_AW,
    parameter int DEPTH   = v_pkg::VWB_DEPTH
);

    logic                       res_valid_i;
    logic                       res_ready_o;
    logic                       res_wen_i;
    logic [VREG_AW-1:0]         res_vd_i;
    logic [VREG_DW-1:0]         res_data_i;
    logic                       vrf_wen_o;
    logic [VREG_AW-1:0]         vrf_waddr_o;
    logic [VREG_DW-1:0]         vrf_wdata_o;
    logic                       vrf_wgnt_i;
    logic [VREG_AW-1:0]         byp_raddr_i;
    logic                       byp_hit_o;
    logic [VREG_DW-1:0]         byp_data_o;
    logic [$clog2(DEPTH):0]     pending_o;

    // The buffer itself
    modport slave (
        input  res_valid_i, res_wen_i, res_vd_i, res_data_i, vrf_wgnt_i, byp_raddr_i,
        output res_ready_o, vrf_wen_o, vrf_waddr_o, vrf_wdata_o, byp_hit_o, byp_data_o, pending_o
    );

    // The ALU lane, VRF arbiter and issue stage seen as one driver
    modport master (
        output res_valid_i, res_wen_i, res_vd_i, res_data_i, vrf_wgnt_i, byp_raddr_i,
        input  res_ready_o, vrf_wen_o, vrf_waddr_o, vrf_wdata_o, byp_hit_o, byp_data_o, pending_o
    );

endinterface

// File: rtl/v_wb_match.sv
// rtl/v_wb_match.sv - youngest-first address match selector over buffer entries
module v_wb_match
    import v_pkg::*;
#(
    parameter  int DEPTH = VWB_DEPTH,
    parameter  int AW    = VREG_AW,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         occ_i,
    input  logic [DEPTH-1:0][AW-1:0] vd_i,
    input  logic [AW-1:0]            raddr_i,
    input  logic [PW-1:0]            newest_i,
    output logic                     hit_o,
    output logic [PW-1:0]            idx_o
);

    logic [PW-1:0] cand;

    // Walk from oldest to youngest so the last match written is the youngest one
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            cand = newest_i - PW'(k);
            if (occ_i[cand] && (vd_i[cand] == raddr_i)) begin
                hit_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/v_wb_2.sv
// rtl/v_wb_2.sv - vector result write-back buffer with VRF write port and bypass
module v_wb_2 #(
    parameter int VREG_DW = v_pkg::VREG_DW,
    parameter int VREG_AW = v_pkg::VREG_AW,
    parameter int DEPTH   = v_pkg::VWB_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    v_wb_2_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]                   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                   count_q, count_d;
    logic [DEPTH-1:0][VREG_AW-1:0]   vd_q, vd_d;
    logic [DEPTH-1:0][VREG_DW-1:0]   data_q, data_d;

    logic                            full;
    logic                            empty;
    logic                            push;
    logic                            pop;
    logic [DEPTH-1:0]                occ;
    logic [PW-1:0]                   rel;
    logic                            match_hit;
    logic [PW-1:0]                   match_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Beats with res_wen_i=0 are consumed by the handshake but never stored
    assign push  = bus.res_valid_i && !full && bus.res_wen_i;
    assign pop   = !empty && bus.vrf_wgnt_i;

    // Next pointer, count and storage contents
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vd_d     = vd_q;
        data_d   = data_q;
        if (push) begin
            vd_d[wr_ptr_q]   = bus.res_vd_i;
            data_d[wr_ptr_q] = bus.res_data_i;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state; reset wins over any push or pop in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is never reset; occupancy comes from the pointers and count
    always_ff @(posedge clk) begin
        vd_q   <= vd_d;
        data_q <= data_d;
    end

    // An entry is occupied when its distance from the head is below count
    always_comb begin
        occ = '0;
        rel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel    = PW'(i) - rd_ptr_q;
            occ[i] = (CW'(rel) < count_q);
        end
    end

    v_wb_match #(
        .DEPTH (DEPTH),
        .AW    (VREG_AW)
    ) u_match (
        .occ_i    (occ),
        .vd_i     (vd_q),
        .raddr_i  (bus.byp_raddr_i),
        .newest_i (wr_ptr_q - PW'(1)),
        .hit_o    (match_hit),
        .idx_o    (match_idx)
    );

    assign bus.res_ready_o = !full;
    assign bus.vrf_wen_o   = !empty;
    assign bus.vrf_waddr_o = vd_q[rd_ptr_q];
    assign bus.vrf_wdata_o = data_q[rd_ptr_q];
    assign bus.byp_hit_o   = match_hit;
    assign bus.byp_data_o  = match_hit ? data_q[match_idx] : '0;
    assign bus.pending_o   = count_q;

endmodule
